// File: rtl/ntt_ctrl_pkg.sv
// Shared NTT control definitions: scheduler state encoding and transform geometry helpers.
// Pure declarations; no logic, no latency.
// Used by the TF scheduler, the NTT top FSM and the address generator.
package ntt_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    WAIT  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4,
    DONE  = 3'd5
  } tf_sched_state_e;

  // log2 of the polynomial degree
  function automatic int f_log2n(input int degree);
    return $clog2(degree);
  endfunction

  // exponent of the tail stage radix; zero means every stage is full radix
  function automatic int f_k2(input int degree, input int k1);
    return f_log2n(degree) % k1;
  endfunction

  // full stages plus an optional tail stage
  function automatic int f_nstage(input int degree, input int k1);
    return (f_log2n(degree) / k1) + ((f_k2(degree, k1) != 0) ? 1 : 0);
  endfunction

  // butterfly groups (twiddle reads) per stage
  function automatic int f_groups(input int degree, input int k1);
    return degree >> k1;
  endfunction

endpackage

// File: rtl/tf_grp_cnt.sv
// Group counter within one NTT stage plus the mod-8 twiddle rotation depth counter.
// Registered counts, terminal-count flag is combinational from the count register.
// Advances only when enabled; wraps to zero on an enabled terminal cycle.
module tf_grp_cnt
  import ntt_ctrl_pkg::*;
#(
  parameter int CW   = 11,
  parameter int TERM = 127
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  output logic [CW-1:0] o_cnt,
  output logic [2:0]    o_depth,
  output logic          o_tc
);

  logic [CW-1:0] r_cnt;
  logic [2:0]    r_depth;

  assign o_tc    = (r_cnt == CW'(TERM));
  assign o_cnt   = r_cnt;
  assign o_depth = r_depth;

  // count groups; the terminal group wraps both counters for the next stage
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt   <= '0;
      r_depth <= '0;
    end else if (i_en) begin
      if (o_tc) begin
        r_cnt   <= '0;
        r_depth <= '0;
      end else begin
        r_cnt   <= r_cnt + CW'(1);
        r_depth <= r_depth + 3'd1;
      end
    end
  end

endmodule

// File: rtl/tf_sched_ctrl.sv
// Twiddle-factor generator sequencer: seeds, runs and drains the TF pipe over all NTT stages.
// done at start+1+NSTAGE*(1+SEED_LAT+GROUPS)+DRAIN_LAT cycles when never stalled.
// stall freezes the RUN phase (TF_ren gated same cycle); abort returns to IDLE next cycle.
module tf_sched_ctrl
  import ntt_ctrl_pkg::*;
#(
  parameter int D_WIDTH   = 64,
  parameter int DEGREE    = 2048,
  parameter int K1        = 4,
  parameter int SEED_LAT  = 3,
  parameter int DRAIN_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               stall,
  input  logic [D_WIDTH-1:0] modulus_in,
  output logic               busy,
  output logic               done,
  output logic               TF_ren,
  output logic               TF_wen,
  output logic               LAST_STAGE,
  output logic [2:0]         l,
  output logic [2:0]         it_depth_cnt,
  output logic [D_WIDTH-1:0] ite_sw_cnt,
  output logic [D_WIDTH-1:0] ite_sw_cnt_ite3,
  output logic [D_WIDTH-1:0] modulus
);

  localparam int LOG2N  = f_log2n(DEGREE);
  localparam int K2     = f_k2(DEGREE, K1);
  localparam int NSTAGE = f_nstage(DEGREE, K1);
  localparam int GROUPS = f_groups(DEGREE, K1);
  // group counter sized by LOG2N, always wide enough for GROUPS-1
  localparam int CW     = LOG2N;
  localparam int TW     = $clog2(SEED_LAT + DRAIN_LAT + 2);

  tf_sched_state_e    r_state;
  tf_sched_state_e    w_state_nxt;
  logic [TW-1:0]      r_tmr;
  logic [2:0]         r_l;
  logic [D_WIDTH-1:0] r_mod;
  logic               r_busy;
  logic               r_done;
  logic               r_tf_wen;
  logic               r_run;

  logic               w_abort_act;
  logic               w_accept;
  logic               w_adv;
  logic               w_tc;
  logic               w_last_l;
  logic [CW-1:0]      w_cnt;
  logic [2:0]         w_depth;

  assign w_abort_act = abort && (r_state != IDLE);
  assign w_accept    = (r_state == IDLE) && start && !abort;
  assign w_adv       = (r_state == RUN) && !stall;
  assign w_last_l    = (r_l == 3'(NSTAGE - 1));

  tf_grp_cnt #(
    .CW   (CW),
    .TERM (GROUPS - 1)
  ) u_grp_cnt (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_clr   (w_abort_act || (r_state == SEED)),
    .i_en    (w_adv && !w_abort_act),
    .o_cnt   (w_cnt),
    .o_depth (w_depth),
    .o_tc    (w_tc)
  );

  // next-state decode; abort outranks every other condition
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort_act) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_accept) w_state_nxt = SEED;
        SEED:    w_state_nxt = WAIT;
        WAIT:    if (r_tmr == TW'(SEED_LAT - 1)) w_state_nxt = RUN;
        RUN:     if (w_adv && w_tc) w_state_nxt = w_last_l ? DRAIN : SEED;
        DRAIN:   if (r_tmr == TW'(DRAIN_LAT - 1)) w_state_nxt = DONE;
        DONE:    w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // dwell timer for the fixed-length WAIT and DRAIN phases, restarted on every state change
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tmr <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmr <= '0;
    end else if ((r_state == WAIT) || (r_state == DRAIN)) begin
      r_tmr <= r_tmr + TW'(1);
    end
  end

  // state, registered strobes, stage index and latched modulus
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_l      <= '0;
      r_mod    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_tf_wen <= 1'b0;
      r_run    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tf_wen <= (w_state_nxt == SEED);
      r_run    <= (w_state_nxt == RUN);
      r_done   <= (w_state_nxt == DONE);
      r_busy   <= (w_state_nxt == SEED) || (w_state_nxt == WAIT) ||
                  (w_state_nxt == RUN)  || (w_state_nxt == DRAIN);
      if (w_accept) begin
        r_mod <= modulus_in;
      end
      // l drops to 0 in DONE so the tail-stage flag ends with the drain
      if (w_abort_act || w_accept || (w_state_nxt == DONE)) begin
        r_l <= '0;
      end else if ((r_state == RUN) && (w_state_nxt == SEED)) begin
        r_l <= r_l + 3'd1;
      end
    end
  end

  // TF_ren comes from the registered RUN phase, gated by this cycle's stall
  assign TF_ren          = r_run && !stall;
  assign TF_wen          = r_tf_wen;
  assign busy            = r_busy;
  assign done            = r_done;
  assign l               = r_l;
  assign modulus         = r_mod;
  assign it_depth_cnt    = w_depth;
  assign ite_sw_cnt      = D_WIDTH'(w_cnt);
  assign ite_sw_cnt_ite3 = ite_sw_cnt >> 3;
  assign LAST_STAGE      = (K2 != 0) && w_last_l;

endmodule
